mem_io_bus: RTL

MEM_IO_BUS -- requirements
Module: mem_io_bus

---
 rtl/mem_io_bus_pkg.sv | 27 ++
 rtl/mem_io_bus_if.sv | 29 ++
 rtl/mem_io_bus_tx_fifo.sv | 76 +++++++
 rtl/mem_io_bus.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mem_io_bus_pkg.sv
// mem_io_bus_pkg -- constants and the address-decode helper shared by the
// mem_io_bus top, its TX FIFO and anything else that decodes the CPU bus.
//   IO_TX_ADDR  : byte IO port (write = UART TX, read = RX byte)
//   IO_CNT_ADDR : halt on write, cycle-counter snapshot on read (+1..+3 = upper bytes)
//   dec_e       : region classification of an 18-bit bus address
package mem_io_bus_pkg;

    localparam logic [17:0] IO_TX_ADDR  = 18'h30000;
    localparam logic [17:0] IO_CNT_ADDR = 18'h30004;

    typedef enum logic [1:0] {
        RAM      = 2'd0,
        IO       = 2'd1,
        UNMAPPED = 2'd2
    } dec_e;

    // Only the low 18 address bits take part in decoding.
    function automatic dec_e decode_addr(input logic [17:0] a);
        if (a[17:16] == 2'b11) begin
            return IO;
        end else if (!a[17]) begin
            return RAM;
        end
        return UNMAPPED;
    endfunction

endpackage

// File: rtl/mem_io_bus_if.sv
// mem_io_bus_if -- CPU bus, RX byte stream and UART TX drain signals of
// mem_io_bus bundled together.
//   slave  : the mem_io_bus side (consumes address/data/handshakes)
//   master : the CPU / environment side
interface mem_io_bus_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halted;
    logic        tx_overflow;

    modport slave (
        input  mem_a, mem_dout, mem_wr, rx_valid, rx_data, tx_ready,
        output mem_din, io_buffer_full, rx_pop, tx_valid, tx_data, halted, tx_overflow
    );

    modport master (
        output mem_a, mem_dout, mem_wr, rx_valid, rx_data, tx_ready,
        input  mem_din, io_buffer_full, rx_pop, tx_valid, tx_data, halted, tx_overflow
    );
endinterface

// File: rtl/mem_io_bus_tx_fifo.sv
// io_tx_fifo -- byte FIFO feeding the UART TX drain port.
//   clk_in, rst_in (async, active-low)
//   i_push/i_data  : enqueue request (dropped when full and not popping)
//   i_ready        : downstream ready; a pop happens on o_valid && i_ready
//   o_valid/o_data : head of queue (o_data forced to 0 while empty)
//   o_near_full    : registered, high while occupancy >= DEPTH-2
//   o_overflow     : sticky, set by any dropped push
module io_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_near_full,
    output logic       o_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);
    localparam logic [PW:0] NEAR_C  = (PW + 1)'(DEPTH - 2);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_near_full;
    logic          r_overflow;

    logic          w_pop;
    logic          w_full;
    logic          w_push_ok;
    logic [PW:0]   w_count_next;

    assign w_pop     = (r_count != '0) && i_ready;
    assign w_full    = (r_count == DEPTH_C);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign w_push_ok = i_push && (!w_full || w_pop);
    assign w_count_next = r_count + {{PW{1'b0}}, w_push_ok} - {{PW{1'b0}}, w_pop};

    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_near_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_next;
            // Computed from the next occupancy so the flag tracks the count with no extra lag.
            r_near_full <= (w_count_next >= NEAR_C);
            if (i_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_valid     = (r_count != '0);
    assign o_data      = o_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign o_near_full = r_near_full;
    assign o_overflow  = r_overflow;
endmodule

// File: rtl/mem_io_bus.sv
// mem_io_bus -- CPU memory/IO bus: byte RAM, UART TX FIFO, RX byte port,
// free-running cycle counter with snapshot, and a sticky halt flag.
//   clk_in  : single clock, rising edge
//   rst_in  : asynchronous active-low reset (RAM contents are kept)
//   bus     : mem_io_bus_if.slave (CPU bus, RX stream, TX drain, status flags)
// Reads return on mem_din one cycle after the address; writes land on the
// same edge. Build option: define MEM_IO_BUS_RX_EN to enable the RX byte
// port at IO_TX_ADDR; otherwise those reads return 0 and rx_pop stays low.
module mem_io_bus
    import mem_io_bus_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    mem_io_bus_if.slave  bus
);
    logic [7:0]  ram [2**RAM_ADDR_W];
    logic [7:0]  r_ram_q;
    dec_e        r_sel;
    logic [7:0]  r_io_q;
    logic [31:0] r_cnt;
    logic [31:0] r_snap;
    logic        r_halted;

    logic [17:0] w_addr;
    dec_e        w_dec;
    logic        w_rd_io;
    logic        w_wr_io;
    logic        w_halt_wr;
    logic        w_tx_push;
    logic [7:0]  w_tx_byte;
    logic        w_rx_take;
    logic [7:0]  w_rx_byte;
    logic [7:0]  w_io_rd;

    assign w_addr    = bus.mem_a[17:0];
    assign w_dec     = decode_addr(w_addr);
    assign w_rd_io   = !bus.mem_wr && (w_dec == IO);
    assign w_wr_io   = bus.mem_wr && (w_dec == IO);
    assign w_halt_wr = w_wr_io && (w_addr == IO_CNT_ADDR);
    // Zero bytes written to the TX port are filtered; the halt write emits a 0x00 marker.
    assign w_tx_push = w_halt_wr || (w_wr_io && (w_addr == IO_TX_ADDR) && (bus.mem_dout != 8'h00));
    assign w_tx_byte = w_halt_wr ? 8'h00 : bus.mem_dout;

`ifdef MEM_IO_BUS_RX_EN
    assign w_rx_take = w_rd_io && (w_addr == IO_TX_ADDR) && bus.rx_valid;
    assign w_rx_byte = bus.rx_valid ? bus.rx_data : 8'h00;
`else
    assign w_rx_take = 1'b0;
    assign w_rx_byte = 8'h00;
`endif
    // Consumption is acknowledged in the read cycle itself so the source can
    // present its next byte for a back-to-back read.
    assign bus.rx_pop = w_rx_take && rst_in;

    always_comb begin
        w_io_rd = 8'h00;
        if (w_addr == IO_TX_ADDR) begin
            w_io_rd = w_rx_byte;
        end else if (w_addr == IO_CNT_ADDR) begin
            w_io_rd = r_cnt[7:0];
        end else if (w_addr == IO_CNT_ADDR + 18'd1) begin
            w_io_rd = r_snap[15:8];
        end else if (w_addr == IO_CNT_ADDR + 18'd2) begin
            w_io_rd = r_snap[23:16];
        end else if (w_addr == IO_CNT_ADDR + 18'd3) begin
            w_io_rd = r_snap[31:24];
        end
    end

    // RAM kept free of reset so it maps onto block RAM with a registered read.
    always_ff @(posedge clk_in) begin
        if (bus.mem_wr && (w_dec == RAM)) begin
            ram[bus.mem_a[RAM_ADDR_W-1:0]] <= bus.mem_dout;
        end
        r_ram_q <= ram[bus.mem_a[RAM_ADDR_W-1:0]];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sel    <= UNMAPPED;
            r_io_q   <= 8'h00;
            r_cnt    <= 32'd0;
            r_snap   <= 32'd0;
            r_halted <= 1'b0;
        end else begin
            // Write cycles return nothing; UNMAPPED selects the 0x00 path.
            r_sel  <= bus.mem_wr ? UNMAPPED : w_dec;
            r_io_q <= w_rd_io ? w_io_rd : 8'h00;
            if (!r_halted && !w_halt_wr) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_halt_wr) begin
                r_halted <= 1'b1;
            end
            // Byte 0 and the snapshot come from the same counter value, so the
            // four-byte read sequence is coherent.
            if (w_rd_io && (w_addr == IO_CNT_ADDR)) begin
                r_snap <= r_cnt;
            end
        end
    end

    assign bus.mem_din = (r_sel == RAM) ? r_ram_q :
                         (r_sel == IO)  ? r_io_q  : 8'h00;
    assign bus.halted  = r_halted;

    io_tx_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_push      (w_tx_push),
        .i_data      (w_tx_byte),
        .i_ready     (bus.tx_ready),
        .o_valid     (bus.tx_valid),
        .o_data      (bus.tx_data),
        .o_near_full (bus.io_buffer_full),
        .o_overflow  (bus.tx_overflow)
    );
endmodule
